// File: rtl/clock_set_controller.sv
// Mode/sequencing controller for the MM:SS clock: 1 Hz tick, button debounce, RUN/SET_MIN/SET_SEC FSM, blink mask.
// Define CLKCTRL_AUTOREPEAT_EN to add auto-repeat of the advance button in the SET states.
module clock_set_controller #(
    parameter int unsigned CLK_HZ       = 50_000_000,
    parameter int unsigned DEBOUNCE_CYC = 1_000_000,
    parameter int unsigned BLINK_DIV    = 25_000_000,
    parameter int unsigned REPEAT_DLY   = 50_000_000,
    parameter int unsigned REPEAT_PER   = 10_000_000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       btn_mode,
    input  logic       btn_adv,
    output logic       tick,
    output logic       inc_min,
    output logic       inc_sec,
    output logic [3:0] blank_mask,
    output logic [1:0] mode
);
    localparam int unsigned PW = $clog2(CLK_HZ + 1);
    localparam int unsigned DW = $clog2(DEBOUNCE_CYC + 1);
    localparam int unsigned BW = $clog2(BLINK_DIV + 1);
    localparam logic [PW-1:0] PRE_LAST   = PW'(CLK_HZ - 1);
    localparam logic [DW-1:0] DEB_LAST   = DW'(DEBOUNCE_CYC - 1);
    localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_DIV - 1);

    typedef enum logic [1:0] {
        RUN     = 2'b00,
        SET_MIN = 2'b01,
        SET_SEC = 2'b10
    } state_t;

    // Bit 0 = mode button, bit 1 = advance button.
    logic [1:0]    sync1_q, sync2_q, deb_q, deb_prev_q;
    logic [DW-1:0] dcnt_q [2];
    logic          mode_press, adv_press, rep_strobe;

    state_t        state_q;
    logic [PW-1:0] pre_q;
    logic [BW-1:0] blink_q;
    logic          phase_q;
    logic          tick_q, inc_min_q, inc_sec_q;
    logic [3:0]    mask_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q    <= '0;
            sync2_q    <= '0;
            deb_q      <= '0;
            deb_prev_q <= '0;
            for (int unsigned i = 0; i < 2; i++) dcnt_q[i] <= '0;
        end else begin
            sync1_q    <= {btn_adv, btn_mode};
            sync2_q    <= sync1_q;
            deb_prev_q <= deb_q;
            // Counter runs only while the synced level disagrees with the accepted one.
            for (int unsigned i = 0; i < 2; i++) begin
                if (sync2_q[i] == deb_q[i]) begin
                    dcnt_q[i] <= '0;
                end else if (dcnt_q[i] == DEB_LAST) begin
                    dcnt_q[i] <= '0;
                    deb_q[i]  <= sync2_q[i];
                end else begin
                    dcnt_q[i] <= dcnt_q[i] + 1'b1;
                end
            end
        end
    end

    assign mode_press = deb_q[0] & ~deb_prev_q[0];
    assign adv_press  = deb_q[1] & ~deb_prev_q[1] & ~mode_press;

`ifdef CLKCTRL_AUTOREPEAT_EN
    localparam int unsigned RMAX = (REPEAT_DLY > REPEAT_PER) ? REPEAT_DLY : REPEAT_PER;
    localparam int unsigned RW   = $clog2(RMAX + 1);
    localparam logic [RW-1:0] DLY_LAST = RW'(REPEAT_DLY - 1);
    localparam logic [RW-1:0] PER_LAST = RW'(REPEAT_PER - 1);

    logic          rep_act_q, rep_first_q;
    logic [RW-1:0] rep_cnt_q;

    assign rep_strobe = rep_act_q & deb_q[1] & ~mode_press &
                        (rep_cnt_q == (rep_first_q ? DLY_LAST : PER_LAST));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rep_act_q   <= 1'b0;
            rep_first_q <= 1'b0;
            rep_cnt_q   <= '0;
        end else if (adv_press && state_q != RUN) begin
            rep_act_q   <= 1'b1;
            rep_first_q <= 1'b1;
            rep_cnt_q   <= '0;
        end else if (!rep_act_q || !deb_q[1] || mode_press) begin
            rep_act_q <= 1'b0;
            rep_cnt_q <= '0;
        end else if (rep_strobe) begin
            rep_first_q <= 1'b0;
            rep_cnt_q   <= '0;
        end else begin
            rep_cnt_q <= rep_cnt_q + 1'b1;
        end
    end
`else
    assign rep_strobe = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= RUN;
            pre_q     <= '0;
            blink_q   <= '0;
            phase_q   <= 1'b0;
            tick_q    <= 1'b0;
            inc_min_q <= 1'b0;
            inc_sec_q <= 1'b0;
            mask_q    <= '0;
        end else begin
            tick_q    <= 1'b0;
            inc_min_q <= 1'b0;
            inc_sec_q <= 1'b0;
            if (state_q == SET_MIN && phase_q)      mask_q <= 4'b1100;
            else if (state_q == SET_SEC && phase_q) mask_q <= 4'b0011;
            else                                    mask_q <= 4'b0000;

            if (mode_press) begin
                pre_q   <= '0;
                blink_q <= '0;
                phase_q <= 1'b0;
                case (state_q)
                    RUN:     state_q <= SET_MIN;
                    SET_MIN: state_q <= SET_SEC;
                    default: state_q <= RUN;
                endcase
            end else if (state_q == RUN) begin
                blink_q <= '0;
                phase_q <= 1'b0;
                if (pre_q == PRE_LAST) begin
                    pre_q  <= '0;
                    tick_q <= 1'b1;
                end else begin
                    pre_q <= pre_q + 1'b1;
                end
            end else begin
                pre_q <= '0;
                if (adv_press || rep_strobe) begin
                    inc_min_q <= (state_q == SET_MIN);
                    inc_sec_q <= (state_q == SET_SEC);
                    blink_q   <= '0;
                    phase_q   <= 1'b0;
                end else if (blink_q == BLINK_LAST) begin
                    blink_q <= '0;
                    phase_q <= ~phase_q;
                end else begin
                    blink_q <= blink_q + 1'b1;
                end
            end
        end
    end

    assign tick       = tick_q;
    assign inc_min    = inc_min_q;
    assign inc_sec    = inc_sec_q;
    assign blank_mask = mask_q;
    assign mode       = state_q;
endmodule

// File: tb/tb_clock_set_controller.sv
// Self-checking bench for clock_set_controller against a window/age based reference model.
// Honours CLKCTRL_AUTOREPEAT_EN the same way the design does.
module tb_clock_set_controller;
    localparam int unsigned CLK_HZ = 10;
    localparam int unsigned DEB    = 4;
    localparam int unsigned BLINK  = 3;
    localparam int unsigned RDLY   = 20;
    localparam int unsigned RPER   = 5;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       btn_mode = 1'b0;
    logic       btn_adv = 1'b0;
    logic       tick, inc_min, inc_sec;
    logic [3:0] blank_mask;
    logic [1:0] mode;

    int vectors = 0;
    int miscompares = 0;
    int n_tick = 0, n_min = 0, n_sec = 0;

    always #5 clk = ~clk;

    clock_set_controller #(
        .CLK_HZ(CLK_HZ), .DEBOUNCE_CYC(DEB), .BLINK_DIV(BLINK),
        .REPEAT_DLY(RDLY), .REPEAT_PER(RPER)
    ) dut (
        .clk(clk), .rst_n(rst_n), .btn_mode(btn_mode), .btn_adv(btn_adv),
        .tick(tick), .inc_min(inc_min), .inc_sec(inc_sec),
        .blank_mask(blank_mask), .mode(mode)
    );

    // Reference model: raw samples delayed two edges, accepted once DEB consecutive samples disagree.
    bit       dly1 [2], dly2 [2];
    bit       win [2][DEB];
    bit       deb [2], deb_prev [2];
    int       st, run_age, blink_age, rep_age;
    bit       rep_on;
    bit       e_tick, e_min, e_sec;
    bit [3:0] e_mask;

    task automatic model_reset();
        for (int b = 0; b < 2; b++) begin
            dly1[b] = 0; dly2[b] = 0; deb[b] = 0; deb_prev[b] = 0;
            for (int k = 0; k < DEB; k++) win[b][k] = 0;
        end
        st = 0; run_age = 0; blink_age = 0; rep_age = 0; rep_on = 0;
        e_tick = 0; e_min = 0; e_sec = 0; e_mask = 4'b0000;
    endtask

    task automatic model_edge(input bit rm, input bit ra);
        bit raw [2];
        bit mp, ap, strobe, phase, seen, flip;
        raw[0] = rm; raw[1] = ra;
        mp = deb[0] && !deb_prev[0];
        ap = deb[1] && !deb_prev[1] && !mp;
        phase = (st != 0) && (((blink_age / BLINK) % 2) == 1);
        if (phase && st == 1)      e_mask = 4'b1100;
        else if (phase && st == 2) e_mask = 4'b0011;
        else                       e_mask = 4'b0000;
        strobe = 0;
`ifdef CLKCTRL_AUTOREPEAT_EN
        if (rep_on && deb[1] && !mp) begin
            rep_age++;
            strobe = (rep_age == RDLY) || (rep_age > RDLY && ((rep_age - RDLY) % RPER) == 0);
        end else begin
            rep_on = 0;
        end
        if (ap && st != 0) begin
            rep_on = 1;
            rep_age = 0;
        end
`endif
        e_tick = 0; e_min = 0; e_sec = 0;
        if (mp) begin
            st = (st + 1) % 3;
            run_age = 0;
            blink_age = 0;
        end else if (st == 0) begin
            run_age++;
            e_tick = (run_age % CLK_HZ) == 0;
        end else if (ap || strobe) begin
            e_min = (st == 1);
            e_sec = (st == 2);
            blink_age = 0;
        end else begin
            blink_age++;
        end
        for (int b = 0; b < 2; b++) begin
            deb_prev[b] = deb[b];
            seen = dly2[b];
            for (int k = DEB - 1; k > 0; k--) win[b][k] = win[b][k-1];
            win[b][0] = seen;
            flip = 1;
            for (int k = 0; k < DEB; k++) if (win[b][k] == deb[b]) flip = 0;
            if (flip) deb[b] = seen;
            dly2[b] = dly1[b];
            dly1[b] = raw[b];
        end
    endtask

    task automatic check();
        bit [1:0] e_mode;
        e_mode = 2'(st);
        vectors++;
        assert (tick === e_tick) else begin
            miscompares++; $error("FAIL tick observed=%0b expected=%0b", tick, e_tick);
        end
        vectors++;
        assert (inc_min === e_min) else begin
            miscompares++; $error("FAIL inc_min observed=%0b expected=%0b", inc_min, e_min);
        end
        vectors++;
        assert (inc_sec === e_sec) else begin
            miscompares++; $error("FAIL inc_sec observed=%0b expected=%0b", inc_sec, e_sec);
        end
        vectors++;
        assert (blank_mask === e_mask) else begin
            miscompares++; $error("FAIL blank_mask observed=%b expected=%b", blank_mask, e_mask);
        end
        vectors++;
        assert (mode === e_mode) else begin
            miscompares++; $error("FAIL mode observed=%b expected=%b", mode, e_mode);
        end
        vectors++;
        assert ((32'(tick) + 32'(inc_min) + 32'(inc_sec)) <= 1) else begin
            miscompares++; $error("FAIL onehot observed=%b expected=at most one", {tick, inc_min, inc_sec});
        end
        n_tick += int'(tick === 1'b1);
        n_min  += int'(inc_min === 1'b1);
        n_sec  += int'(inc_sec === 1'b1);
    endtask

    task automatic cyc(input bit m, input bit a);
        btn_mode = m;
        btn_adv  = a;
        @(posedge clk);
        model_edge(m, a);
        #1 check();
    endtask

    task automatic press_mode();
        repeat (10) cyc(1, 0);
        repeat (10) cyc(0, 0);
    endtask

    task automatic expect_count(input string tag, input int observed, input int expected);
        vectors++;
        assert (observed == expected) else begin
            miscompares++; $error("FAIL %s observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    int base_t, base_m, base_s, rep_expect;

    initial begin
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        #1 check();

        // Idle after reset: ticks on cycles 10, 20, 30.
        base_t = n_tick;
        repeat (35) cyc(0, 0);
        expect_count("ticks_35", n_tick - base_t, 3);

        // Mode cycling, then first tick 10 cycles after RUN re-entry.
        press_mode();
        expect_count("mode_set_min", int'(mode), 1);
        press_mode();
        expect_count("mode_set_sec", int'(mode), 2);
        press_mode();
        expect_count("mode_run", int'(mode), 0);
        repeat (15) cyc(0, 0);

        // SET_MIN: short glitch ignored, clean press gives one increment.
        press_mode();
        base_m = n_min;
        repeat (2) cyc(0, 1);
        repeat (10) cyc(0, 0);
        expect_count("glitch_inc", n_min - base_m, 0);
        repeat (10) cyc(0, 1);
        repeat (10) cyc(0, 0);
        expect_count("clean_inc", n_min - base_m, 1);

        // SET_SEC idle: blinking, no ticks.
        press_mode();
        base_t = n_tick;
        repeat (12) cyc(0, 0);
        expect_count("set_no_tick", n_tick - base_t, 0);

        // Aligned mode/adv edges in SET_MIN: mode wins.
        press_mode();
        press_mode();
        base_m = n_min; base_s = n_sec;
        repeat (10) cyc(1, 1);
        repeat (10) cyc(0, 0);
        expect_count("aligned_mode", int'(mode), 2);
        expect_count("aligned_inc", (n_min - base_m) + (n_sec - base_s), 0);

        // Long hold of adv in SET_MIN.
        press_mode();
        press_mode();
        base_m = n_min;
        repeat (39) cyc(0, 1);
        repeat (10) cyc(0, 0);
`ifdef CLKCTRL_AUTOREPEAT_EN
        rep_expect = 5;
`else
        rep_expect = 1;
`endif
        expect_count("hold_incs", n_min - base_m, rep_expect);

        // Asynchronous reset in the middle of a hold.
        repeat (30) cyc(0, 1);
        #2;
        rst_n = 1'b0;
        btn_adv = 1'b0;
        model_reset();
        #1 check();
        @(negedge clk);
        rst_n = 1'b1;
        #1 check();

        // Random button activity.
        repeat (60) begin
            bit m, a;
            int len;
            m = ($urandom_range(0, 3) == 0);
            a = ($urandom_range(0, 1) == 1);
            len = $urandom_range(1, 14);
            repeat (len) cyc(m, a);
        end
        repeat (20) cyc(0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
